// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute sequencer for an 8-bit CPU.
// It fetches a one- or two-byte instruction over a simple read port, then
// produces one-cycle ALU and register-write strobes. HLT stops it, halt_req
// stops it at the next instruction boundary, and a stalled memory read
// times out into HALT with err set.
//
// Memory handshake: mem_req is the request valid and mem_ack is the ready.
// While mem_req is high, mem_addr holds steady at pc. The read completes on
// the first rising edge where both are high, and mem_rdata is captured on
// that edge. mem_ack is ignored while mem_req is low. An ack is allowed on
// the very first cycle of a request.
module cpu_sequencer #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       halt_req,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic [7:0] pc,
    output logic [7:0] ir,
    output logic [7:0] opr,
    output logic       alu_en,
    output logic       reg_we,
    output logic [2:0] state,
    output logic       halted,
    output logic       err,
    output logic [7:0] instr_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_FETCH2 = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    // The wait counter only needs to reach ACK_TIMEOUT-1. The timeout fires
    // on the edge that would have made it ACK_TIMEOUT, so mem_req is high
    // for exactly ACK_TIMEOUT cycles before it is dropped.
    localparam int                WAIT_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    state_t            state_q;
    logic [7:0]        pc_q;
    logic [7:0]        ir_q;
    logic [7:0]        opr_q;
    logic [7:0]        instr_cnt_q;
    logic              mem_req_q;
    logic              alu_en_q;
    logic              reg_we_q;
    logic              err_q;
    logic [WAIT_W-1:0] wait_q;

    logic [3:0]        op;
    logic [7:0]        pc_inc_d;
    logic [7:0]        instr_cnt_d;
    logic              ack_take;
    logic              no_wb;

    assign op          = ir_q[7:4];
    assign pc_inc_d    = pc_q + 8'd1;
    assign instr_cnt_d = instr_cnt_q + 8'd1;
    assign ack_take    = mem_req_q && mem_ack;
    // NOP and JMP finish in EXEC; they do not use the ALU or write back.
    assign no_wb       = (op == OP_NOP) || (op == OP_JMP);

    // Sequencer FSM: all state, datapath registers and strobes update here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= 8'h00;
            opr_q       <= 8'h00;
            instr_cnt_q <= 8'h00;
            mem_req_q   <= 1'b0;
            alu_en_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            err_q       <= 1'b0;
            wait_q      <= '0;
        end else begin
            // Strobes are single-cycle: they are low unless set below.
            alu_en_q <= 1'b0;
            reg_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_FETCH;
                        mem_req_q <= 1'b1;
                        wait_q    <= '0;
                    end
                end
                ST_FETCH, ST_FETCH2: begin
                    if (ack_take) begin
                        pc_q   <= pc_inc_d;
                        wait_q <= '0;
                        if (state_q == ST_FETCH) begin
                            ir_q <= mem_rdata;
                            if (mem_rdata[7]) begin
                                // The operand read starts at once, and pc has
                                // already moved to the next byte.
                                state_q <= ST_FETCH2;
                            end else begin
                                state_q   <= ST_DECODE;
                                mem_req_q <= 1'b0;
                            end
                        end else begin
                            opr_q     <= mem_rdata;
                            state_q   <= ST_DECODE;
                            mem_req_q <= 1'b0;
                        end
                    end else if (mem_req_q) begin
                        if (wait_q == WAIT_LAST) begin
                            // Stalled read: give up and leave pc/ir/opr as
                            // they were, so a restart retries the same byte.
                            state_q   <= ST_HALT;
                            mem_req_q <= 1'b0;
                            err_q     <= 1'b1;
                            wait_q    <= '0;
                        end else begin
                            wait_q <= wait_q + WAIT_W'(1);
                        end
                    end
                end
                ST_DECODE: begin
                    if (op == OP_HLT) begin
                        // HLT counts as a completed instruction.
                        state_q     <= ST_HALT;
                        instr_cnt_q <= instr_cnt_d;
                    end else begin
                        state_q  <= ST_EXEC;
                        alu_en_q <= !no_wb;
                    end
                end
                ST_EXEC: begin
                    if (op == OP_JMP) begin
                        pc_q <= opr_q;
                    end
                    if (no_wb) begin
                        instr_cnt_q <= instr_cnt_d;
                        if (halt_req) begin
                            state_q <= ST_HALT;
                        end else begin
                            state_q   <= ST_FETCH;
                            mem_req_q <= 1'b1;
                            wait_q    <= '0;
                        end
                    end else begin
                        state_q  <= ST_WB;
                        reg_we_q <= 1'b1;
                    end
                end
                ST_WB: begin
                    instr_cnt_q <= instr_cnt_d;
                    if (halt_req) begin
                        state_q <= ST_HALT;
                    end else begin
                        state_q   <= ST_FETCH;
                        mem_req_q <= 1'b1;
                        wait_q    <= '0;
                    end
                end
                ST_HALT: begin
                    // start takes priority over a concurrent halt_req.
                    if (start) begin
                        state_q   <= ST_FETCH;
                        mem_req_q <= 1'b1;
                        err_q     <= 1'b0;
                        wait_q    <= '0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign opr       = opr_q;
    assign alu_en    = alu_en_q;
    assign reg_we    = reg_we_q;
    assign state     = state_q;
    assign halted    = (state_q == ST_HALT);
    assign err       = err_q;
    assign instr_cnt = instr_cnt_q;

endmodule
